// File: rtl/btn_event_detector_pkg.sv
// btn_pkg: shared types and default timing for the push-button front end.
//   btn_state_t        - button classifier FSM states
//   BTN_DEBOUNCE_10MS  - 10 ms at 27 MHz
//   BTN_LONG_1S        - 1 s at 27 MHz
//   BTN_REPEAT_250MS   - 250 ms at 27 MHz
//   max3()             - largest of three values (counter sizing)
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG_HELD,
    RELEASE_DB
  } btn_state_t;

  localparam int unsigned BTN_DEBOUNCE_10MS = 270_000;
  localparam int unsigned BTN_LONG_1S       = 27_000_000;
  localparam int unsigned BTN_REPEAT_250MS  = 6_750_000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_event_detector_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer for asynchronous board inputs.
//   RST_VAL  - level both flops take during reset
//   clk      - destination clock
//   rst_n    - asynchronous active-low reset
//   d        - asynchronous input
//   q        - synchronized output
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_event_detector.sv
// btn_event_detector: synchronizes and debounces one push-button, classifies
// presses as short or long and emits single-cycle event pulses.
//   clk          - 27 MHz system clock
//   rst_n        - asynchronous active-low reset
//   btn_raw      - raw button pin (asynchronous)
//   btn_level    - debounced pressed level
//   short_press  - pulse on release of a press that never went long
//   long_press   - pulse when a press has been held LONG_CYCLES
//   repeat_pulse - auto-repeat pulse while long-held (0 unless BTN_REPEAT_EN)
// Build option: define BTN_REPEAT_EN to enable auto-repeat in LONG_HELD.
module btn_event_detector
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_10MS,
  parameter int unsigned LONG_CYCLES     = BTN_LONG_1S,
  parameter int unsigned REPEAT_CYCLES   = BTN_REPEAT_250MS,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W =
    $clog2(max3(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic             sync_q;
  logic             btn_s;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             was_long, was_long_nxt;
  logic             level_nxt, short_nxt, long_nxt;

  // Reset value is the released pin level so reset never looks like a press.
  sync_2ff #(.RST_VAL(BTN_ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (sync_q)
  );

  assign btn_s = sync_q ^ BTN_ACTIVE_LOW;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic rep_nxt;
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    was_long_nxt = was_long;
    level_nxt    = btn_level;
    short_nxt    = 1'b0;
    long_nxt     = 1'b0;
`ifdef BTN_REPEAT_EN
    rep_nxt      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_DB;
          cnt_nxt   = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt    = RELEASE_DB;
          cnt_nxt      = '0;
          was_long_nxt = 1'b0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!btn_s) begin
          state_nxt    = RELEASE_DB;
          cnt_nxt      = '0;
          was_long_nxt = 1'b1;
        end else begin
`ifdef BTN_REPEAT_EN
          if (cnt == REP_LAST) begin
            rep_nxt = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      RELEASE_DB: begin
        if (btn_s) begin
          // Bounce: resume the held state; long/repeat timing restarts.
          state_nxt = was_long ? LONG_HELD : HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt    = IDLE;
          cnt_nxt      = '0;
          level_nxt    = 1'b0;
          short_nxt    = ~was_long;
          was_long_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      was_long    <= 1'b0;
      btn_level   <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      was_long    <= was_long_nxt;
      btn_level   <= level_nxt;
      short_press <= short_nxt;
      long_press  <= long_nxt;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) repeat_pulse <= 1'b0;
    else        repeat_pulse <= rep_nxt;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_detector.sv
// tb_btn_event_detector: self-checking bench for btn_event_detector.
// A timestamp-based reference model predicts every output each cycle; directed
// scenarios pin event latencies with literal values, then random press/release
// segments exercise the model comparison. Honors BTN_REPEAT_EN.
module tb_btn_event_detector;

  localparam int DEB     = 4;
  localparam int LNG     = 20;
  localparam int REP     = 8;
  localparam bit ACT_LOW = 1'b1;
`ifdef BTN_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic btn_raw = ACT_LOW;
  logic btn_level, short_press, long_press, repeat_pulse;

  always #5 clk = ~clk;

  btn_event_detector #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
    .REPEAT_CYCLES   (REP),
    .BTN_ACTIVE_LOW  (ACT_LOW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .short_press  (short_press),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Reference model: the level flips once the synchronized input has disagreed
  // with it for DEB+1 consecutive samples; long/repeat events are timestamps
  // relative to the latest uninterrupted stretch of pressed samples.
  logic h0 = ACT_LOW, h1 = ACT_LOW;
  bit   m_level = 0, m_long_done = 0, in_opp = 0;
  bit   e_short = 0, e_long = 0, e_rep = 0;
  int   mn = 0, first_opp = 0, base = 0, rbase = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      h0 = ACT_LOW; h1 = ACT_LOW;
      m_level = 0; m_long_done = 0; in_opp = 0;
      e_short = 0; e_long = 0; e_rep = 0;
      mn = 0; first_opp = 0; base = 0; rbase = 0;
    end else begin
      bit s;
      mn++;
      s  = h1 ^ ACT_LOW;
      h1 = h0;
      h0 = btn_raw;
      e_short = 0; e_long = 0; e_rep = 0;
      if (s != m_level) begin
        if (!in_opp) begin
          in_opp    = 1;
          first_opp = mn;
        end
        if (mn - first_opp == DEB) begin
          in_opp = 0;
          if (m_level) begin
            m_level     = 0;
            e_short     = !m_long_done;
            m_long_done = 0;
          end else begin
            m_level = 1;
            base    = mn;
          end
        end
      end else if (in_opp) begin
        in_opp = 0;
        if (m_level) begin
          base  = mn;
          rbase = mn;
        end
      end else if (m_level) begin
        if (!m_long_done) begin
          if (mn - base == LNG) begin
            e_long      = 1;
            m_long_done = 1;
            rbase       = mn;
          end
        end else if (REP_ON && ((mn - rbase) % REP == 0)) begin
          e_rep = 1;
        end
      end
    end
  end

  // Compare process plus event bookkeeping used by the directed checks.
  int n_rise = 0, n_fall = 0, n_short = 0, n_long = 0, n_rep = 0;
  int rise_edge = 0, fall_edge = 0, short_edge = 0, long_edge = 0;
  int rep_q[$];
  bit prev_level = 0;

  initial forever begin
    @(negedge clk);
    chk("btn_level",    int'(btn_level),    int'(m_level));
    chk("short_press",  int'(short_press),  int'(e_short));
    chk("long_press",   int'(long_press),   int'(e_long));
    chk("repeat_pulse", int'(repeat_pulse), int'(e_rep));
    chk("pulse_excl", int'($countones({short_press, long_press, repeat_pulse}) <= 1), 1);
    if (btn_level && !prev_level) begin n_rise++; rise_edge = edge_cnt; end
    if (!btn_level && prev_level) begin n_fall++; fall_edge = edge_cnt; end
    if (short_press)  begin n_short++; short_edge = edge_cnt; end
    if (long_press)   begin n_long++;  long_edge  = edge_cnt; end
    if (repeat_pulse) begin n_rep++;   rep_q.push_back(edge_cnt); end
    prev_level = btn_level;
  end

  // Changes the pin just after an edge; e is the first edge that samples it.
  task automatic set_btn(input bit pressed, output int e);
    @(posedge clk);
    #2;
    btn_raw = pressed ^ ACT_LOW;
    e = edge_cnt + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int p, r, a, b, c, q;
    int s0, l0, f0, r0, rp0;
    bit pressed;

    // Reset state
    idle(3);
    @(negedge clk);
    chk("rst_btn_level", int'(btn_level), 0);
    chk("rst_pulses", int'({short_press, long_press, repeat_pulse}), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(5);

    // Glitch: pressed for 3 sampled cycles
    r0 = n_rise; s0 = n_short; l0 = n_long;
    set_btn(1, p); idle(2);
    set_btn(0, r); idle(15);
    chk("glitch_rise", n_rise - r0, 0);
    chk("glitch_short", n_short - s0, 0);
    chk("glitch_long", n_long - l0, 0);

    // Short press: 10 cycles
    s0 = n_short; l0 = n_long;
    set_btn(1, p); idle(9);
    set_btn(0, r); idle(15);
    chk("short_rise_lat", rise_edge - p, 6);
    chk("short_fall_lat", fall_edge - r, 6);
    chk("short_count", n_short - s0, 1);
    chk("short_lat", short_edge - r, 6);
    chk("short_no_long", n_long - l0, 0);

    // Long press: 60 cycles
    s0 = n_short; l0 = n_long; rp0 = n_rep;
    rep_q.delete();
    set_btn(1, p); idle(59);
    set_btn(0, r); idle(20);
    chk("long_rise_lat", rise_edge - p, 6);
    chk("long_after_rise", long_edge - rise_edge, 20);
    chk("long_count", n_long - l0, 1);
    chk("long_no_short", n_short - s0, 0);
    chk("rep_count", n_rep - rp0, REP_ON ? 4 : 0);
    chk("rep1_offset", (rep_q.size() > 0) ? rep_q[0] - long_edge : 0, REP_ON ? 8 : 0);
    chk("rep2_offset", (rep_q.size() > 1) ? rep_q[1] - long_edge : 0, REP_ON ? 16 : 0);

    // Release bounce: 10 pressed, 2 released, 1 pressed, released
    r0 = n_rise; f0 = n_fall; s0 = n_short;
    set_btn(1, p); idle(9);
    set_btn(0, a); idle(1);
    set_btn(1, b);
    set_btn(0, c); idle(20);
    chk("bounce_rise", n_rise - r0, 1);
    chk("bounce_fall", n_fall - f0, 1);
    chk("bounce_short", n_short - s0, 1);
    chk("bounce_fall_lat", fall_edge - c, 6);

    // Reset mid-press
    set_btn(1, p); idle(11);
    @(posedge clk);
    #2;
    chk("pre_reset_level", int'(btn_level), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_level", int'(btn_level), 0);
    chk("mid_reset_pulses", int'({short_press, long_press, repeat_pulse}), 0);
    idle(1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    q = edge_cnt + 1;
    s0 = n_short; l0 = n_long; rp0 = n_rep;
    idle(15);
    chk("post_reset_rise_lat", rise_edge - q, 6);
    chk("post_reset_no_pulse", (n_short - s0) + (n_long - l0) + (n_rep - rp0), 0);
    set_btn(0, r); idle(15);
    chk("post_reset_short", n_short - s0, 1);
    chk("post_reset_no_long", n_long - l0, 0);

    // Random press/release segments
    pressed = 1'b0;
    for (int i = 0; i < 160; i++) begin
      int sel, dur;
      sel = int'($urandom_range(0, 9));
      if (sel < 3)      dur = int'($urandom_range(1, 5));
      else if (sel < 8) dur = int'($urandom_range(6, 30));
      else              dur = int'($urandom_range(31, 80));
      pressed = ~pressed;
      set_btn(pressed, p);
      idle(dur - 1);
    end
    set_btn(0, r);
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
